// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared rename constants and register index types
package rename_pkg;

  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS = 64;
  localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH;

  localparam int ARCH_W   = 5;
  localparam int PHYS_W   = 6;
  localparam int FL_PTR_W = 5;
  localparam int FL_CNT_W = 6;

  typedef logic [ARCH_W-1:0] arch_reg_t;
  typedef logic [PHYS_W-1:0] phys_reg_t;

endpackage

// File: rtl/rename_free_list.sv
// rtl/rename_free_list.sv - circular FIFO of free physical registers
// The caller gates pop/push; this block does not protect against underflow or overflow.
module rename_free_list
  import rename_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      pop_i,
  input  logic      push_i,
  input  phys_reg_t push_data_i,
  output phys_reg_t head_data_o,
  output logic      empty_o,
  output logic      full_o
);

  logic [FL_PTR_W-1:0] head_q, head_d;
  logic [FL_PTR_W-1:0] tail_q, tail_d;
  logic [FL_CNT_W-1:0] count_q, count_d;
  phys_reg_t           mem_q [FL_DEPTH];

  // Pointers are FL_PTR_W bits wide and FL_DEPTH is 2**FL_PTR_W, so they wrap naturally.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_i) head_d = head_q + FL_PTR_W'(1);
    if (push_i) tail_d = tail_q + FL_PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + FL_CNT_W'(1);
      2'b01:   count_d = count_q - FL_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= FL_CNT_W'(FL_DEPTH);
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem_q[i] <= phys_reg_t'(NUM_ARCH + i);
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_i) mem_q[tail_q] <= push_data_i;
    end
  end

  assign head_data_o = mem_q[head_q];
  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == FL_CNT_W'(FL_DEPTH));

endmodule

// File: rtl/reg_rename_unit.sv
// rtl/reg_rename_unit.sv - RAT lookup/update and free-list allocation for the rename stage
// Optional: RENAME_X0_FIXED_EN pins architectural x0 to physical register 0.
module reg_rename_unit
  import rename_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  arch_reg_t rd,
  input  arch_reg_t rs1,
  input  arch_reg_t rs2,
  input  logic      issue_valid,
  input  logic      retire_valid,
  input  phys_reg_t retire_phys_reg,
  output phys_reg_t phys_rd,
  output phys_reg_t phys_rs1,
  output phys_reg_t phys_rs2,
  output phys_reg_t old_phys_rd,
  output logic      free_list_empty
);

  phys_reg_t rat_q [NUM_ARCH];
  phys_reg_t fl_head;
  logic      fl_empty;
  logic      fl_full;
  logic      rd_fixed;
  logic      rename_fire;
  logic      fl_push;

`ifdef RENAME_X0_FIXED_EN
  assign rd_fixed = (rd == '0);
`else
  assign rd_fixed = 1'b0;
`endif

  assign rename_fire = issue_valid && !rd_fixed && !fl_empty;
  // A retire into a full list is still accepted when an issue pops in the same cycle.
  assign fl_push     = retire_valid && (!fl_full || rename_fire);

  rename_free_list u_free_list (
    .clk         (clk),
    .reset_n     (reset_n),
    .pop_i       (rename_fire),
    .push_i      (fl_push),
    .push_data_i (retire_phys_reg),
    .head_data_o (fl_head),
    .empty_o     (fl_empty),
    .full_o      (fl_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        rat_q[i] <= phys_reg_t'(i);
      end
    end else if (rename_fire) begin
      rat_q[rd] <= fl_head;
    end
  end

  assign phys_rs1        = rat_q[rs1];
  assign phys_rs2        = rat_q[rs2];
  assign old_phys_rd     = rd_fixed ? '0 : rat_q[rd];
  assign phys_rd         = rd_fixed ? '0 : fl_head;
  assign free_list_empty = fl_empty;

endmodule

// File: tb/tb_reg_rename_unit.sv
// tb/tb_reg_rename_unit.sv - scoreboard bench for reg_rename_unit against a queue-based model
module tb_reg_rename_unit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic       issue_valid = 1'b0, retire_valid = 1'b0;
  logic [5:0] retire_phys_reg = '0;
  logic [5:0] phys_rd, phys_rs1, phys_rs2, old_phys_rd;
  logic       free_list_empty;

  reg_rename_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rd              (rd),
    .rs1             (rs1),
    .rs2             (rs2),
    .issue_valid     (issue_valid),
    .retire_valid    (retire_valid),
    .retire_phys_reg (retire_phys_reg),
    .phys_rd         (phys_rd),
    .phys_rs1        (phys_rs1),
    .phys_rs2        (phys_rs2),
    .old_phys_rd     (old_phys_rd),
    .free_list_empty (free_list_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int prd;
    int prs1;
    int prs2;
    int old;
    int empty;
    bit chk_prd;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int rat[32];
  int fl[$];

`ifdef RENAME_X0_FIXED_EN
  localparam bit X0_FIXED = 1'b1;
`else
  localparam bit X0_FIXED = 1'b0;
`endif

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) rat[i] = i;
    fl.delete();
    for (int i = 0; i < 32; i++) fl.push_back(32 + i);
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    bit   fixed;
    fixed     = X0_FIXED && (rd == 5'd0);
    e.prs1    = rat[rs1];
    e.prs2    = rat[rs2];
    e.old     = fixed ? 0 : rat[rd];
    e.empty   = (fl.size() == 0) ? 1 : 0;
    // Head contents of an empty list are stale and not part of the contract.
    e.chk_prd = fixed || (fl.size() > 0);
    e.prd     = fixed ? 0 : ((fl.size() > 0) ? fl[0] : 0);
    return e;
  endfunction

  function automatic void model_commit();
    bit pop, push;
    pop  = issue_valid && !(X0_FIXED && rd == 5'd0) && (fl.size() > 0);
    push = retire_valid && ((fl.size() < 32) || pop);
    if (pop) rat[rd] = fl.pop_front();
    if (push) fl.push_back(int'(retire_phys_reg));
  endfunction

  task automatic step(input int rd_v, input int rs1_v, input int rs2_v,
                      input int iv, input int rv, input int rreg);
    rd              = 5'(rd_v);
    rs1             = 5'(rs1_v);
    rs2             = 5'(rs2_v);
    issue_valid     = (iv != 0);
    retire_valid    = (rv != 0);
    retire_phys_reg = 6'(rreg);
    sb_q.push_back(model_expect());
    model_commit();
    @(posedge clk);
    #1;
  endtask

  // Reset is asserted between edges; the check lands before the next edge.
  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    sb_q.push_back(model_expect());
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic random_steps(input int n, input int retire_pct);
    for (int k = 0; k < n; k++) begin
      step($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           ($urandom_range(0, 99) < 60) ? 1 : 0,
           ($urandom_range(0, 99) < retire_pct) ? 1 : 0,
           $urandom_range(0, 63));
    end
  endtask

  function automatic void cmp(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endfunction

  exp_t mon_e;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      if (mon_e.chk_prd) cmp("phys_rd", int'(phys_rd), mon_e.prd);
      cmp("phys_rs1", int'(phys_rs1), mon_e.prs1);
      cmp("phys_rs2", int'(phys_rs2), mon_e.prs2);
      cmp("old_phys_rd", int'(old_phys_rd), mon_e.old);
      cmp("free_list_empty", int'(free_list_empty), mon_e.empty);
    end
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    step(1, 2, 3, 1, 0, 0);
    step(2, 4, 1, 1, 0, 0);
    step(3, 5, 2, 1, 0, 0);
    step(0, 1, 2, 0, 0, 0);

    do_reset();
    for (int k = 0; k < 32; k++) step(5, 5, 5, 1, 0, 0);
    step(5, 5, 0, 1, 0, 0);
    step(0, 5, 0, 0, 1, 7);
    step(4, 4, 5, 1, 0, 0);
    step(0, 4, 0, 0, 0, 0);

    for (int k = 0; k < 10; k++) step(0, 4, 5, 0, 1, 40 + k);
    step(6, 6, 0, 1, 1, 32);
    for (int k = 0; k < 11; k++) step(k % 8 + 8, 6, k % 8 + 8, 1, 0, 0);
    step(0, 6, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    do_reset();
    random_steps(300, 25);
    random_steps(300, 80);
    random_steps(200, 50);
    do_reset();
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    random_steps(300, 50);

    repeat (2) @(negedge clk);
    cmp("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
